sys_ctrl_burst: RTL

Command-frame controller that sits between the RX data synchronizer, register file, gated ALU and async TX FIFO in the REF_CLK domain. It is the parametrised successor of the single-access system controller. It adds:
- generic address, data and ALU-result widths
- burst register read/write commands
- FIFO backpressure on every transmitted byte
- an inter-byte timeout
- command-error reporting

---
 rtl/sys_ctrl_burst_if.sv | 45 ++++
 rtl/sys_ctrl_burst.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_ctrl_burst_if.sv
`default_nettype none
// ============================================================================
// Module   : sys_ctrl_burst_if
// Brief    : Bus bundle between sys_ctrl_burst and the RX sync, register
//            file, gated ALU and TX FIFO.
// Revision : 1.0 - initial release
// ============================================================================
interface sys_ctrl_burst_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int FUN_WIDTH     = 4,
    parameter int ALU_OUT_BYTES = 2
);
    logic [DATA_WIDTH-1:0]               RX_P_DATA;
    logic                                RX_D_VLD;
    logic [DATA_WIDTH-1:0]               RdData;
    logic                                RdData_Valid;
    logic [ALU_OUT_BYTES*DATA_WIDTH-1:0] ALU_OUT;
    logic                                OUT_Valid;
    logic                                FIFO_FULL;
    logic [FUN_WIDTH-1:0]                ALU_FUN;
    logic                                EN;
    logic                                CLK_EN;
    logic [ADDR_WIDTH-1:0]               Address;
    logic                                WrEn;
    logic                                RdEn;
    logic [DATA_WIDTH-1:0]               WrData;
    logic [DATA_WIDTH-1:0]               TX_P_DATA;
    logic                                TX_D_VLD;
    logic                                CMD_ERR;
    logic                                BUSY;

    modport master (
        input  RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, OUT_Valid, FIFO_FULL,
        output ALU_FUN, EN, CLK_EN, Address, WrEn, RdEn, WrData, TX_P_DATA, TX_D_VLD,
               CMD_ERR, BUSY
    );

    modport slave (
        output RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, OUT_Valid, FIFO_FULL,
        input  ALU_FUN, EN, CLK_EN, Address, WrEn, RdEn, WrData, TX_P_DATA, TX_D_VLD,
               CMD_ERR, BUSY
    );
endinterface
`default_nettype wire

// File: rtl/sys_ctrl_burst.sv
`default_nettype none
// ============================================================================
// Module   : sys_ctrl_burst
// Brief    : Command-frame controller with burst register access, ALU
//            sequencing, TX FIFO backpressure, inter-byte timeout, errors.
// Revision : 1.0 - initial release
// ============================================================================
module sys_ctrl_burst #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int FUN_WIDTH      = 4,
    parameter int ALU_OUT_BYTES  = 2,
    parameter int BURST_MAX      = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire logic        clk,
    input  wire logic        RST,
    sys_ctrl_burst_if.master bus
);
    localparam int c_RES_W = ALU_OUT_BYTES * DATA_WIDTH;
    localparam int c_CNT_W = $clog2(BURST_MAX + 1);
    localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int c_TXL_W = $clog2(ALU_OUT_BYTES + 1);

    localparam logic [DATA_WIDTH-1:0] c_CMD_WR  = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] c_CMD_RD  = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] c_CMD_ALU = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] c_CMD_FUN = DATA_WIDTH'(8'hDD);
    localparam logic [DATA_WIDTH-1:0] c_CMD_BW  = DATA_WIDTH'(8'hEE);
    localparam logic [DATA_WIDTH-1:0] c_CMD_BR  = DATA_WIDTH'(8'hFF);

    localparam logic [3:0] c_S_IDLE     = 4'd0;
    localparam logic [3:0] c_S_GET_ADDR = 4'd1;
    localparam logic [3:0] c_S_GET_DATA = 4'd2;
    localparam logic [3:0] c_S_GET_A    = 4'd3;
    localparam logic [3:0] c_S_GET_B    = 4'd4;
    localparam logic [3:0] c_S_GET_FUN  = 4'd5;
    localparam logic [3:0] c_S_GET_N    = 4'd6;
    localparam logic [3:0] c_S_BW_DATA  = 4'd7;
    localparam logic [3:0] c_S_RD_WAIT  = 4'd8;
    localparam logic [3:0] c_S_RD_NEXT  = 4'd9;
    localparam logic [3:0] c_S_ALU_WAIT = 4'd10;
    localparam logic [3:0] c_S_TX       = 4'd11;

    logic [3:0]            r_state,   w_state;
    logic [DATA_WIDTH-1:0] r_cmd,     w_cmd;
    logic [ADDR_WIDTH-1:0] r_ptr,     w_ptr;
    logic [c_CNT_W-1:0]    r_cnt,     w_cnt;
    logic [c_RES_W-1:0]    r_tx_buf,  w_tx_buf;
    logic [c_TXL_W-1:0]    r_tx_left, w_tx_left;
    logic [c_TMO_W-1:0]    r_tmo,     w_tmo;
    logic [FUN_WIDTH-1:0]  r_alu_fun, w_alu_fun;
    logic                  r_en,      w_en;
    logic [ADDR_WIDTH-1:0] r_addr,    w_addr;
    logic                  r_wren,    w_wren;
    logic                  r_rden,    w_rden;
    logic [DATA_WIDTH-1:0] r_wrdata,  w_wrdata;
    logic [DATA_WIDTH-1:0] r_tx_data, w_tx_data;
    logic                  r_tx_vld,  w_tx_vld;
    logic                  r_err,     w_err;
    logic                  r_busy;
    logic                  w_waiting;

    always_comb begin
        w_state   = r_state;
        w_cmd     = r_cmd;
        w_ptr     = r_ptr;
        w_cnt     = r_cnt;
        w_tx_buf  = r_tx_buf;
        w_tx_left = r_tx_left;
        w_tmo     = '0;
        w_alu_fun = r_alu_fun;
        w_en      = r_en;
        w_addr    = r_addr;
        w_wrdata  = r_wrdata;
        w_tx_data = r_tx_data;
        w_wren    = 1'b0;
        w_rden    = 1'b0;
        w_tx_vld  = 1'b0;
        w_err     = 1'b0;
        w_waiting = r_state inside {c_S_GET_ADDR, c_S_GET_DATA, c_S_GET_A, c_S_GET_B,
                                    c_S_GET_FUN, c_S_GET_N, c_S_BW_DATA};

        // An arriving byte always beats a simultaneous timeout expiry.
        if (w_waiting && !bus.RX_D_VLD) begin
            if (r_tmo == c_TMO_W'(TIMEOUT_CYCLES - 1)) begin
                w_err   = 1'b1;
                w_state = c_S_IDLE;
            end else begin
                w_tmo = r_tmo + c_TMO_W'(1);
            end
        end
        if (!w_waiting && (r_state != c_S_IDLE) && bus.RX_D_VLD)
            w_err = 1'b1;

        case (r_state)
            c_S_IDLE: if (bus.RX_D_VLD) begin
                w_cmd = bus.RX_P_DATA;
                case (bus.RX_P_DATA)
                    c_CMD_WR, c_CMD_RD, c_CMD_BW, c_CMD_BR: w_state = c_S_GET_ADDR;
                    c_CMD_ALU: w_state = c_S_GET_A;
                    c_CMD_FUN: w_state = c_S_GET_FUN;
                    default:   w_err   = 1'b1;
                endcase
            end
            c_S_GET_ADDR: if (bus.RX_D_VLD) begin
                w_ptr = bus.RX_P_DATA[ADDR_WIDTH-1:0];
                if (r_cmd == c_CMD_WR) begin
                    w_state = c_S_GET_DATA;
                end else if (r_cmd == c_CMD_RD) begin
                    w_rden  = 1'b1;
                    w_addr  = bus.RX_P_DATA[ADDR_WIDTH-1:0];
                    w_cnt   = c_CNT_W'(1);
                    w_state = c_S_RD_WAIT;
                end else begin
                    w_state = c_S_GET_N;
                end
            end
            c_S_GET_DATA: if (bus.RX_D_VLD) begin
                w_wren   = 1'b1;
                w_addr   = r_ptr;
                w_wrdata = bus.RX_P_DATA;
                w_state  = c_S_IDLE;
            end
            c_S_GET_A: if (bus.RX_D_VLD) begin
                w_wren   = 1'b1;
                w_addr   = ADDR_WIDTH'(0);
                w_wrdata = bus.RX_P_DATA;
                w_state  = c_S_GET_B;
            end
            c_S_GET_B: if (bus.RX_D_VLD) begin
                w_wren   = 1'b1;
                w_addr   = ADDR_WIDTH'(1);
                w_wrdata = bus.RX_P_DATA;
                w_state  = c_S_GET_FUN;
            end
            c_S_GET_FUN: if (bus.RX_D_VLD) begin
                w_alu_fun = bus.RX_P_DATA[FUN_WIDTH-1:0];
                w_en      = 1'b1;
                w_state   = c_S_ALU_WAIT;
            end
            c_S_GET_N: if (bus.RX_D_VLD) begin
                if ((bus.RX_P_DATA == '0) || (bus.RX_P_DATA > DATA_WIDTH'(BURST_MAX))) begin
                    w_err   = 1'b1;
                    w_state = c_S_IDLE;
                end else begin
                    w_cnt = c_CNT_W'(bus.RX_P_DATA);
                    if (r_cmd == c_CMD_BW) begin
                        w_state = c_S_BW_DATA;
                    end else begin
                        w_rden  = 1'b1;
                        w_addr  = r_ptr;
                        w_state = c_S_RD_WAIT;
                    end
                end
            end
            c_S_BW_DATA: if (bus.RX_D_VLD) begin
                w_wren   = 1'b1;
                w_addr   = r_ptr;
                w_wrdata = bus.RX_P_DATA;
                w_ptr    = r_ptr + ADDR_WIDTH'(1);
                w_cnt    = r_cnt - c_CNT_W'(1);
                if (r_cnt == c_CNT_W'(1))
                    w_state = c_S_IDLE;
            end
            c_S_RD_WAIT: if (bus.RdData_Valid) begin
                w_tx_buf                 = '0;
                w_tx_buf[DATA_WIDTH-1:0] = bus.RdData;
                w_tx_left                = c_TXL_W'(1);
                w_state                  = c_S_TX;
            end
            c_S_RD_NEXT: begin
                w_rden  = 1'b1;
                w_addr  = r_ptr;
                w_state = c_S_RD_WAIT;
            end
            c_S_ALU_WAIT: if (bus.OUT_Valid) begin
                w_en      = 1'b0;
                w_tx_buf  = bus.ALU_OUT;
                w_tx_left = c_TXL_W'(ALU_OUT_BYTES);
                w_state   = c_S_TX;
            end
            c_S_TX: if (!bus.FIFO_FULL) begin
                w_tx_vld  = 1'b1;
                w_tx_data = r_tx_buf[DATA_WIDTH-1:0];
                w_tx_buf  = r_tx_buf >> DATA_WIDTH;
                w_tx_left = r_tx_left - c_TXL_W'(1);
                if (r_tx_left == c_TXL_W'(1)) begin
                    // Next burst read is held off until this byte is in the FIFO.
                    if ((r_cmd == c_CMD_BR) && (r_cnt > c_CNT_W'(1))) begin
                        w_cnt   = r_cnt - c_CNT_W'(1);
                        w_ptr   = r_ptr + ADDR_WIDTH'(1);
                        w_state = c_S_RD_NEXT;
                    end else begin
                        w_state = c_S_IDLE;
                    end
                end
            end
            default: w_state = c_S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            r_state   <= c_S_IDLE;
            r_cmd     <= '0;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_tx_buf  <= '0;
            r_tx_left <= '0;
            r_tmo     <= '0;
            r_alu_fun <= '0;
            r_en      <= 1'b0;
            r_addr    <= '0;
            r_wren    <= 1'b0;
            r_rden    <= 1'b0;
            r_wrdata  <= '0;
            r_tx_data <= '0;
            r_tx_vld  <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_cmd     <= w_cmd;
            r_ptr     <= w_ptr;
            r_cnt     <= w_cnt;
            r_tx_buf  <= w_tx_buf;
            r_tx_left <= w_tx_left;
            r_tmo     <= w_tmo;
            r_alu_fun <= w_alu_fun;
            r_en      <= w_en;
            r_addr    <= w_addr;
            r_wren    <= w_wren;
            r_rden    <= w_rden;
            r_wrdata  <= w_wrdata;
            r_tx_data <= w_tx_data;
            r_tx_vld  <= w_tx_vld;
            r_err     <= w_err;
            r_busy    <= (w_state != c_S_IDLE);
        end
    end

    assign bus.ALU_FUN   = r_alu_fun;
    assign bus.EN        = r_en;
    assign bus.CLK_EN    = r_en;
    assign bus.Address   = r_addr;
    assign bus.WrEn      = r_wren;
    assign bus.RdEn      = r_rden;
    assign bus.WrData    = r_wrdata;
    assign bus.TX_P_DATA = r_tx_data;
    assign bus.TX_D_VLD  = r_tx_vld;
    assign bus.CMD_ERR   = r_err;
    assign bus.BUSY      = r_busy;
endmodule
`default_nettype wire
